// File: rtl/gyro_pkg.sv
// gyro_pkg -- shared definitions for the gyro SPI slave.
//   * FSM state encoding (also exported on the slave's debug state port)
//   * WHO_AM_I address/value
//   * register-file address and data widths
package gyro_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] WHO_AM_I_ADDR = 6'h0F;
    localparam logic [DATA_W-1:0] WHO_AM_I_VAL  = 8'hD3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } gyro_state_t;

endpackage

// File: rtl/gyro_sync.sv
// gyro_sync -- 2-flop synchronizer plus rise/fall edge detector for one
// asynchronous input.
// Ports:
//   gyroclk    system clock
//   gyroreset  asynchronous active-high reset (all flops load RESET_VAL)
//   din        asynchronous input
//   dout       synchronized level
//   rise/fall  one-cycle pulses on synchronized edges
// RESET_VAL is the input's idle level, so leaving reset never fakes an edge.
module gyro_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic gyroclk,
    input  logic gyroreset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge gyroclk or posedge gyroreset) begin
        if (gyroreset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/gyro_slave.sv
// gyro_slave -- SPI slave (CPOL=1, CPHA=1, MSB first) in front of a 64x8
// register file. Address 0x0F is the read-only WHO_AM_I register (0xD3).
// Ports:
//   gyroclk, gyroreset      system clock, async active-high reset
//   gyross, gyrosclk        SPI select (active low) and clock (idles high)
//   gyrosdi, gyrosdo        SPI data in / out (gyrosdo idles at 1)
//   regwr, regwaddr,        one-cycle strobe with address/data of each
//   regwdata                committed SPI write
//   regsel, regsdata        host-side combinational read port
//   busy                    synchronized gyross is low
//   fsmstate                debug view of the transaction FSM (gyro_state_t)
// Build option: define GYRO_SLAVE_MULTIBYTE_EN to honour the MS bit
// (address auto-increment with continued transfer). Undefined, only the first
// data byte of a transaction is used.
//
// regwr handshake: valid-only strobe, there is no ready. regwr is high for
// exactly one gyroclk cycle per committed byte and regwaddr/regwdata are valid
// in that cycle; the consumer must take it then. The register file already
// holds the new value in the cycle regwr is high.
module gyro_slave
    import gyro_pkg::*;
(
    input  logic              gyroclk,
    input  logic              gyroreset,
    input  logic              gyross,
    input  logic              gyrosclk,
    input  logic              gyrosdi,
    output logic              gyrosdo,
    output logic              regwr,
    output logic [ADDR_W-1:0] regwaddr,
    output logic [DATA_W-1:0] regwdata,
    input  logic [ADDR_W-1:0] regsel,
    output logic [DATA_W-1:0] regsdata,
    output logic              busy,
    output logic [1:0]        fsmstate
);

    // ---------------- input synchronizers ----------------
    logic ss_s, ss_rise, ss_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic sdi_s, sdi_rise, sdi_fall;

    gyro_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .gyroclk(gyroclk), .gyroreset(gyroreset), .din(gyross),
        .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    gyro_sync #(.RESET_VAL(1'b1)) u_sync_sclk (
        .gyroclk(gyroclk), .gyroreset(gyroreset), .din(gyrosclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    gyro_sync #(.RESET_VAL(1'b0)) u_sync_sdi (
        .gyroclk(gyroclk), .gyroreset(gyroreset), .din(gyrosdi),
        .dout(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
    );

    // A transaction may only start after gyross has been seen high once the
    // synchronizer has refilled after reset. This keeps a reset that lands
    // while the master holds gyross low from starting mid-stream.
    logic [1:0] sync_fill;
    logic       armed;

    always_ff @(posedge gyroclk or posedge gyroreset) begin
        if (gyroreset) begin
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && ss_s) armed <= 1'b1;
        end
    end

    // ---------------- FSM ----------------
    gyro_state_t state_q, state_d;

    logic [2:0]        bitcnt;
    logic [7:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic              rw;
    logic              ms;
    logic [ADDR_W-1:0] addr;
    logic              done;
    logic              sdo_q;

    always_ff @(posedge gyroclk or posedge gyroreset) begin
        if (gyroreset) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ss_fall && armed) state_d = ST_CMD;
            ST_CMD:  if (sclk_rise && bitcnt == 3'd7) state_d = ST_DATA;
            ST_DATA: state_d = ST_DATA;
            default: state_d = ST_IDLE;
        endcase
        // Deselect wins over everything, including a same-cycle clock edge.
        if (ss_rise) state_d = ST_IDLE;
    end

    // ---------------- datapath decode ----------------
    logic [7:0]        byte_in;
    logic              cmd_last;
    logic              byte_done;
    logic              data_fall;
    logic              wr_commit;
    logic              cont;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] tx_addr;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] mem [64];

    assign byte_in   = {rx_sr[6:0], sdi_s};
    assign cmd_last  = (state_q == ST_CMD) && sclk_rise && !ss_rise && (bitcnt == 3'd7);
    assign byte_done = (state_q == ST_DATA) && sclk_rise && !ss_rise && !done &&
                       (bitcnt == 3'd7);
    assign data_fall = (state_q == ST_DATA) && sclk_fall && !ss_rise && rw;
    assign wr_commit = byte_done && !rw && (addr != WHO_AM_I_ADDR);
    assign next_addr = addr + 6'd1;

`ifdef GYRO_SLAVE_MULTIBYTE_EN
    assign cont = ms;
`else
    assign cont = 1'b0;
`endif

    // TX load source: the command's address at the end of the command byte,
    // otherwise the incremented address for a multibyte reload.
    assign tx_addr = (state_q == ST_CMD) ? byte_in[5:0] : next_addr;
    assign tx_data = (tx_addr == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : mem[tx_addr];

    always_ff @(posedge gyroclk or posedge gyroreset) begin
        if (gyroreset) begin
            bitcnt   <= '0;
            rx_sr    <= '0;
            tx_sr    <= 8'hFF;
            rw       <= 1'b0;
            ms       <= 1'b0;
            addr     <= '0;
            done     <= 1'b0;
            sdo_q    <= 1'b1;
            regwr    <= 1'b0;
            regwaddr <= '0;
            regwdata <= '0;
        end else begin
            regwr <= 1'b0;
            if (state_q == ST_IDLE || ss_rise) begin
                bitcnt <= '0;
                done   <= 1'b0;
                tx_sr  <= 8'hFF;
                sdo_q  <= 1'b1;
            end else begin
                if (sclk_rise && !done) begin
                    rx_sr  <= byte_in;
                    bitcnt <= bitcnt + 3'd1;
                end
                if (cmd_last) begin
                    rw    <= byte_in[7];
                    ms    <= byte_in[6];
                    addr  <= byte_in[5:0];
                    tx_sr <= byte_in[7] ? tx_data : 8'hFF;
                end
                if (byte_done) begin
                    if (wr_commit) begin
                        regwr    <= 1'b1;
                        regwaddr <= addr;
                        regwdata <= byte_in;
                    end
                    if (cont) begin
                        addr <= next_addr;
                        if (rw) tx_sr <= tx_data;
                    end else begin
                        done <= 1'b1;
                    end
                end
                // Ones shift in behind the data, so gyrosdo returns to 1
                // after the last valid bit.
                if (data_fall) begin
                    sdo_q <= tx_sr[7];
                    tx_sr <= {tx_sr[6:0], 1'b1};
                end
            end
        end
    end

    // ---------------- register file ----------------
    // 0x0F is never written; reads of it are substituted with WHO_AM_I_VAL.
    always_ff @(posedge gyroclk or posedge gyroreset) begin
        if (gyroreset) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (wr_commit) begin
            mem[addr] <= byte_in;
        end
    end

    assign regsdata = (regsel == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : mem[regsel];
    assign gyrosdo  = sdo_q;
    assign busy     = ~ss_s;
    assign fsmstate = state_q;

    logic unused_sig;
`ifdef GYRO_SLAVE_MULTIBYTE_EN
    assign unused_sig = &{1'b0, sclk_s, sdi_rise, sdi_fall};
`else
    assign unused_sig = &{1'b0, sclk_s, sdi_rise, sdi_fall, ms};
`endif

endmodule
